// File: rtl/demux_pkg.sv
//------------------------------------------------------------------------------
// Module      : demux_pkg
// Description : Shared constants and state encoding for the 1:16 deserializer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package demux_pkg;

  localparam int WIDTH = 16;
  localparam int SEL_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RECV   = 2'b01,
    PARITY = 2'b10
  } state_e;

endpackage

`default_nettype wire

// File: rtl/dec_4x16.sv
//------------------------------------------------------------------------------
// Module      : dec_4x16
// Description : Combinational 4-to-16 one-hot decoder with an enable gate.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dec_4x16
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [WIDTH-1:0] onehot
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_dec
      assign onehot[gi] = en && (sel == SEL_W'(gi));
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/demux_1x16_sync.sv
//------------------------------------------------------------------------------
// Module      : demux_1x16_sync
// Description : Synchronous 1:16 serial-to-parallel deserializer, LSB first.
//               Optional even-parity trailer bit enabled by DEMUX_PARITY_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module demux_1x16_sync
  import demux_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic             in_bit,
  output logic [WIDTH-1:0] Y,
  output logic             y_valid,
  output logic             busy,
  output logic [SEL_W-1:0] idx,
  output logic             par_err
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic [WIDTH-1:0] bit_we;
  logic             last_bit;

`ifdef DEMUX_PARITY_EN
  logic             par_err_q, par_err_d;
`endif

  // start outranks data, so a start cycle never writes the shadow register
  dec_4x16 u_dec (
    .sel    (idx_q),
    .en     (in_valid && !start && (state_q == RECV)),
    .onehot (bit_we)
  );

  assign last_bit = (idx_q == SEL_W'(WIDTH - 1));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    shadow_d  = shadow_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
`ifdef DEMUX_PARITY_EN
    par_err_d = par_err_q;
`endif

    for (int i = 0; i < WIDTH; i++) begin
      if (bit_we[i]) begin
        shadow_d[i] = in_bit;
      end
    end

    if (start) begin
      state_d  = RECV;
      idx_d    = '0;
      shadow_d = '0;
    end else begin
      case (state_q)
        RECV: begin
          if (in_valid) begin
            idx_d = idx_q + SEL_W'(1);
            if (last_bit) begin
`ifdef DEMUX_PARITY_EN
              state_d = PARITY;
`else
              state_d   = IDLE;
              y_d       = shadow_d;
              y_valid_d = 1'b1;
`endif
            end
          end
        end
`ifdef DEMUX_PARITY_EN
        PARITY: begin
          if (in_valid) begin
            state_d   = IDLE;
            y_d       = shadow_q;
            par_err_d = (^shadow_q) ^ in_bit;
            y_valid_d = 1'b1;
          end
        end
`endif
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      shadow_q  <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end

`ifdef DEMUX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

  assign Y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q != IDLE);
  assign idx     = idx_q;

endmodule

`default_nettype wire

// File: tb/tb_demux_1x16_sync.sv
//------------------------------------------------------------------------------
// Module      : tb_demux_1x16_sync
// Description : Directed-vector bench for demux_1x16_sync (DEMUX_PARITY_EN aware).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_demux_1x16_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_bit;
  logic [15:0] Y;
  logic        y_valid;
  logic        busy;
  logic [3:0]  idx;
  logic        par_err;

  int n_vec  = 0;
  int n_err  = 0;
  int vcount = 0;

  demux_1x16_sync dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .Y        (Y),
    .y_valid  (y_valid),
    .busy     (busy),
    .idx      (idx),
    .par_err  (par_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (y_valid === 1'b1) vcount++;
  end

  task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    in_valid = 1'b1;
    in_bit   = b;
    cycle();
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  // start, then nbits bits of w LSB first with 0..maxgap idle cycles before each
  task automatic send_word(input logic [15:0] w, input int nbits, input int maxgap);
    logic [15:0] wv;
    wv = w;
    pulse_start();
    for (int k = 0; k < nbits; k++) begin
      int gap;
      gap = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
      for (int g = 0; g < gap; g++) begin
        in_bit = ~wv[k];
        cycle();
        if (g == 0) check_vec("idx_stall", 32'(idx), 32'(k));
      end
      send_bit(wv[k]);
    end
  endtask

  // parity trailer only exists in the parity build
  task automatic close_frame(input logic p);
`ifdef DEMUX_PARITY_EN
    check_vec("par_wait_vld", 32'(y_valid), 32'd0);
    check_vec("par_wait_busy", 32'(busy), 32'd1);
    send_bit(p);
`else
    if (p) in_bit = 1'b0;
`endif
  endtask

  task automatic check_done(input string tag, input logic [15:0] w);
    check_vec({tag, "_Y"}, 32'(Y), 32'(w));
    check_vec({tag, "_vld"}, 32'(y_valid), 32'd1);
    check_vec({tag, "_busy"}, 32'(busy), 32'd0);
    check_vec({tag, "_idx"}, 32'(idx), 32'd0);
  endtask

  initial begin
    int v0;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
    check_vec("rst_Y", 32'(Y), 32'h0);
    check_vec("rst_vld", 32'(y_valid), 32'd0);
    check_vec("rst_busy", 32'(busy), 32'd0);
    check_vec("rst_idx", 32'(idx), 32'd0);
    check_vec("rst_par", 32'(par_err), 32'd0);

    // in IDLE data is ignored
    send_bit(1'b1);
    check_vec("idle_idx", 32'(idx), 32'd0);
    check_vec("idle_busy", 32'(busy), 32'd0);

    // reset mid-frame
    v0 = vcount;
    send_word(16'hFFFF, 7, 0);
    check_vec("mid_idx", 32'(idx), 32'd7);
    check_vec("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check_vec("mrst_Y", 32'(Y), 32'h0);
    check_vec("mrst_idx", 32'(idx), 32'd0);
    check_vec("mrst_busy", 32'(busy), 32'd0);
    cycle();
    check_vec("mrst_pulses", 32'(vcount), 32'(v0));

    // A5C3 continuous
    v0 = vcount;
    send_word(16'hA5C3, 16, 0);
    close_frame(1'b0);
    check_done("a5c3", 16'hA5C3);
    check_vec("a5c3_par", 32'(par_err), 32'd0);
    cycle();
    check_vec("a5c3_vld_off", 32'(y_valid), 32'd0);
    check_vec("a5c3_pulses", 32'(vcount), 32'(v0 + 1));

    // A5C3 with random gaps
    v0 = vcount;
    send_word(16'hA5C3, 16, 3);
    close_frame(1'b0);
    check_done("gap", 16'hA5C3);
    cycle(); cycle();
    check_vec("gap_pulses", 32'(vcount), 32'(v0 + 1));

    // abort after 10 bits, then 1234
    v0 = vcount;
    send_word(16'hFFFF, 10, 0);
    check_vec("abort_idx", 32'(idx), 32'd10);
    send_word(16'h1234, 16, 0);
    close_frame(1'b1);
    check_done("w1234", 16'h1234);
    cycle();
    check_vec("w1234_pulses", 32'(vcount), 32'(v0 + 1));

    // start together with the 16th bit of 00FF
    v0 = vcount;
    send_word(16'h00FF, 15, 0);
    start = 1'b1; in_valid = 1'b1; in_bit = 1'b0;
    cycle();
    start = 1'b0; in_valid = 1'b0;
    check_vec("coll_vld", 32'(y_valid), 32'd0);
    check_vec("coll_Y", 32'(Y), 32'h1234);
    check_vec("coll_busy", 32'(busy), 32'd1);
    check_vec("coll_idx", 32'(idx), 32'd0);
    cycle();
    check_vec("coll_pulses", 32'(vcount), 32'(v0));

    // restarted frame carries on without a new start
    for (int k = 0; k < 16; k++) send_bit(k == 0 || k == 15);
    close_frame(1'b0);
    check_done("w8001", 16'h8001);

`ifdef DEMUX_PARITY_EN
    send_word(16'hA5C3, 16, 0);
    close_frame(1'b1);
    check_done("perr", 16'hA5C3);
    check_vec("perr_flag", 32'(par_err), 32'd1);
    send_word(16'hA5C3, 16, 0);
    close_frame(1'b0);
    check_vec("pok_flag", 32'(par_err), 32'd0);
`endif

    cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/demux_1x16_sync.md
Name: demux_1x16_sync

Overview:
Synchronous 1-to-16 demultiplexing deserializer: the receive end of a 16:1 bit-select serial link. It accepts one bit per qualified cycle and steers it into output position Y[idx], where idx counts 0..15. When all 16 bits have arrived it publishes the word with a one-cycle valid pulse. It sits at the receive side of the bit-serial lab datapath, paired with a counter-driven 16:1 mux transmitter.

Parameters:
WIDTH, 16, word width; fixed at 16 for this revision.
SEL_W, 4, index width, equal to log2(WIDTH).

Ports:
clk  input  1  single system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  frame start pulse; clears the index and enters receive.
in_valid  input  1  in_bit is qualified this cycle.
in_bit  input  1  serial data bit.
Y  output  16  last completed word, registered.
y_valid  output  1  one-cycle pulse when Y updates.
busy  output  1  high while a frame is in progress (RECV or PARITY).
idx  output  4  index of the next bit to be written.
par_err  output  1  parity error for the word in Y; constant 0 when the optional feature is disabled.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; Y=16'h0000; shadow=0; idx=0.
  - y_valid=0, busy=0, par_err=0.
  - rst has priority over every other input; a frame in progress is discarded and y_valid is not pulsed.
- States: IDLE, RECV, PARITY (PARITY exists only when the optional feature is enabled).
- IDLE:
  - in_valid/in_bit are ignored.
  - start=1 -> RECV, idx=0, shadow=0.
  - The in_bit present in the start cycle is not captured.
- RECV:
  - Each cycle with in_valid=1: shadow[idx] <= in_bit, then idx <= idx+1.
  - Cycles with in_valid=0 hold all state; there is no timeout.
- Bit ordering: bits are LSB first, so the k-th accepted bit lands in Y[k].
- Completion (in_valid=1 with idx=15, feature disabled):
  - At that edge: Y <= {in_bit, shadow[14:0]}, y_valid=1 for exactly the following cycle, idx wraps to 0, state -> IDLE.
  - Latency is 0 cycles from the last bit's edge to Y/y_valid visible.
- start during RECV or PARITY:
  - Aborts the current frame: idx=0, shadow=0, stays or returns to RECV.
  - No y_valid is produced; Y and par_err keep their old values.
  - start has priority over in_valid in the same cycle.
- start in the same cycle as the final bit: the abort wins and the word is dropped.
- Y, par_err: hold their values between y_valid pulses.
- busy = (state != IDLE).
- idx reads 0 whenever the state is IDLE.

Optional Feature:
Macro: DEMUX_PARITY_EN
- Defined:
  - After the 16th data bit, go to PARITY instead of completing.
  - The next in_valid bit is the even-parity bit p. At that edge: Y <= word, par_err <= (^word) ^ p, y_valid pulse, state -> IDLE.
  - in_valid=0 in PARITY holds state; start in PARITY aborts as described above.
- Undefined: the PARITY state is not built and par_err is tied to 0.

Decomposition:
- Package demux_pkg contains:
  - WIDTH=16 and SEL_W=4 constants.
  - State typedef: IDLE=2'b00, RECV=2'b01, PARITY=2'b10.
- Natural sub-module: dec_4x16, a combinational 4-to-16 one-hot decoder that turns idx into per-bit write enables for shadow, gated by in_valid.
- FSM, counter and output registers stay in the top module.

Test Plan:
1. Reset mid-frame: start, send 7 bits, assert rst for 1 cycle -> Y=0000, idx=0, busy=0, no y_valid; the next frame then completes normally.
2. Word 16'hA5C3, LSB first (1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1), in_valid continuous -> at the 16th bit's edge Y=A5C3, y_valid high for 1 cycle, busy drops, idx=0.
3. Same word with in_valid gaps of 0-3 random cycles between bits -> identical Y=A5C3, a single y_valid pulse, idx stalls during gaps.
4. start after 10 bits of 16'hFFFF, then the full word 16'h1234 -> Y=1234 and exactly one y_valid pulse.
5. start coincident with the 16th bit of 16'h00FF -> no y_valid, Y keeps its previous value, state=RECV, idx=0.
6. With DEMUX_PARITY_EN: A5C3 plus p=0 -> par_err=0; A5C3 plus p=1 -> par_err=1; y_valid only after the parity bit.
